uart_prog_loader: RTL and testbench
===================================

# uart_prog_loader

Boot/program-load controller for the single-cycle MIPS core. It takes a byte stream from the UART receiver, frames it into 32-bit words and writes them into instruction or data memory while holding the CPU in reset. It releases the CPU when the host sends the end command. It sits beside the CPU top and owns the CPU reset and the memory write ports for the whole load window.

## Interface
Parameters:
- ADDR_W, 14, word-address width of both memory write ports
- TIMEOUT, 2_000_000, idle cycles allowed between bytes inside a frame before error

Ports:
- clock  in  1  system clock (CPU clock domain); UART bytes are already synchronised to it
- rst  in  1  asynchronous, active-high reset
- prog_req  in  1  single-cycle pulse (debounced button) requesting load mode
- rx_valid  in  1  one-cycle strobe, rx_data valid
- rx_data  in  8  received byte
- cpu_rst  out  1  reset to CPU datapath, high while not in RUN
- imem_we  out  1  instruction-memory write strobe, one cycle per word
- dmem_we  out  1  data-memory write strobe, one cycle per word
- wr_addr  out  ADDR_W  word address for the current strobe
- wr_data  out  32  word for the current strobe
- loading  out  1  high in every state except RUN
- err  out  1  sticky error flag

## Operation
- States: RUN, CMD, CNT0, CNT1, DATA, ERR.
- Reset: state RUN, all outputs 0 except cpu_rst=1. cpu_rst drops to 0 on the first clock edge after rst deasserts.
- RUN:
  - CPU executes.
  - prog_req goes to CMD and clears err.
  - rx_valid is ignored.
- CMD: next byte selects the action.
  - 0x49 'I': target imem, go to CNT0.
  - 0x44 'D': target dmem, go to CNT0.
  - 0x45 'E': go to RUN.
  - Any other byte: go to ERR.
- CNT0 and CNT1 capture the 16-bit word count, little-endian (low byte first).
  - Count 0 goes straight back to CMD with no writes.
  - Otherwise go to DATA, clearing the address counter and the byte index.
- DATA:
  - Bytes are assembled little-endian: the first byte goes to [7:0], the fourth to [31:24].
  - On the fourth byte, pulse the target's write strobe with wr_addr = address counter, then increment the address and decrement the count.
  - When the count reaches 0, go to CMD.
- Address counter is ADDR_W bits and wraps modulo 2^ADDR_W; overflow is not an error.
- Timeout:
  - A counter runs in CNT0, CNT1 and DATA and resets on every accepted byte.
  - When it reaches TIMEOUT, go to ERR.
  - No timeout in CMD or RUN.
- ERR:
  - err=1, CPU stays in reset, bytes are ignored.
  - prog_req goes to CMD and clears err.
- prog_req in any load state restarts at CMD. Any partial word, count and address are discarded; no strobe is emitted for them.
- imem_we and dmem_we are never high in the same cycle.
- wr_addr and wr_data are don't-care when no strobe is high.

## Timing
- At most one byte accepted per cycle.
- Write latency: the strobe is registered and asserts in the cycle after the fourth byte's rx_valid. wr_addr and wr_data are stable in that same cycle.
- cpu_rst and loading:
  - Both assert in the cycle after prog_req is sampled in RUN.
  - Both deassert in the cycle after the 'E' byte is sampled.
  - The final write strobe of a section always precedes cpu_rst deassertion by at least 2 cycles. The 'E' byte can be accepted at the earliest one cycle after the strobe.
- Simultaneous events:
  - prog_req together with rx_valid: prog_req wins and the byte is dropped.
  - rx_valid together with a timeout expiry: the byte wins and the counter reloads.
- rst asserted mid-load: immediate return to RUN with cpu_rst=1. Memory contents are left as already written.

## Structure
- Shared package `loader_pkg` contains:
  - the state enum
  - command constants CMD_IMEM=8'h49, CMD_DMEM=8'h44, CMD_END=8'h45
- Sub-module `word_assembler` contains:
  - the byte-index counter and 32-bit shift/pack register
  - ports: clock, rst, clr, byte_valid, byte_in → word_valid pulse, word_out
- The top level keeps the FSM, count, address and timeout counters.

## Test plan
- Reset, then idle → cpu_rst=1 for exactly one cycle after rst falls, then 0. loading=0, err=0, no strobes.
- prog_req; bytes 49 02 00 78 56 34 12 EF BE AD DE 45 → imem_we at addr 0 data 0x12345678, then addr 1 data 0xDEADBEEF. cpu_rst falls the cycle after 0x45. dmem_we never high.
- prog_req; 44 00 00 then 45 → no writes, back to RUN.
- prog_req; 44 01 00 AA BB, then silence for TIMEOUT cycles → err=1, state ERR, no strobe. A later prog_req clears err.
- prog_req; bad command 0x7F → err=1. Further bytes are ignored until prog_req.
- ADDR_W=2 build, 'I' with count 5 → addresses 0,1,2,3,0. Mid-word prog_req in a separate run produces no strobe.

Source files
------------

// File: rtl/loader_pkg.sv
// Shared definitions for the UART program loader: FSM state encoding and
// host command bytes.
package loader_pkg;

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned WORD_W  = 32;
   localparam int unsigned COUNT_W = 16;

   typedef logic [2:0] state_t;

   localparam state_t ST_RUN  = 3'd0;
   localparam state_t ST_CMD  = 3'd1;
   localparam state_t ST_CNT0 = 3'd2;
   localparam state_t ST_CNT1 = 3'd3;
   localparam state_t ST_DATA = 3'd4;
   localparam state_t ST_ERR  = 3'd5;

   localparam logic [BYTE_W-1:0] CMD_IMEM = 8'h49;
   localparam logic [BYTE_W-1:0] CMD_DMEM = 8'h44;
   localparam logic [BYTE_W-1:0] CMD_END  = 8'h45;

endpackage

// File: rtl/word_assembler.sv
// Packs four little-endian bytes into a 32-bit word; word_valid pulses for
// one cycle after the fourth byte, with word_out stable in that cycle.
module word_assembler
   import loader_pkg::*;
(
   input  logic              clock,
   input  logic              rst,
   input  logic              clr,
   input  logic              byte_valid,
   input  logic [BYTE_W-1:0] byte_in,
   output logic              word_valid,
   output logic [WORD_W-1:0] word_out
);

   logic [1:0]               idx;
   logic [WORD_W-BYTE_W-1:0] pack;

   // Shift right so the first byte ends up in the lowest lane.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         idx        <= 2'd0;
         pack       <= '0;
         word_valid <= 1'b0;
         word_out   <= '0;
      end else begin
         word_valid <= 1'b0;
         if (clr) begin
            idx <= 2'd0;
         end else if (byte_valid) begin
            if (idx == 2'd3) begin
               word_out   <= {byte_in, pack};
               word_valid <= 1'b1;
               idx        <= 2'd0;
            end else begin
               pack <= {byte_in, pack[WORD_W-BYTE_W-1:BYTE_W]};
               idx  <= idx + 2'd1;
            end
         end
      end
   end

endmodule

// File: rtl/uart_prog_loader.sv
// Boot loader: frames UART bytes into words, writes imem/dmem while holding
// the CPU in reset, and releases it on the end command.
module uart_prog_loader
   import loader_pkg::*;
#(
   parameter int unsigned ADDR_W  = 14,
   parameter int unsigned TIMEOUT = 2_000_000
) (
   input  logic              clock,
   input  logic              rst,
   input  logic              prog_req,
   input  logic              rx_valid,
   input  logic [BYTE_W-1:0] rx_data,
   output logic              cpu_rst,
   output logic              imem_we,
   output logic              dmem_we,
   output logic [ADDR_W-1:0] wr_addr,
   output logic [WORD_W-1:0] wr_data,
   output logic              loading,
   output logic              err
);

   localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);
   localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT);

   state_t               state, state_n;
   logic [COUNT_W-1:0]   count, count_n, cnt_full_c;
   logic [ADDR_W-1:0]    addr, addr_n;
   logic [TMO_W-1:0]     tmo, tmo_n;
   logic                 tgt_dmem, tgt_dmem_n;
   logic                 asm_clr_c, asm_byte_c;
   logic                 word_valid;
   logic [WORD_W-1:0]    word_out;

   word_assembler u_asm (
      .clock      (clock),
      .rst        (rst),
      .clr        (asm_clr_c),
      .byte_valid (asm_byte_c),
      .byte_in    (rx_data),
      .word_valid (word_valid),
      .word_out   (word_out)
   );

   // State, counters and registered status outputs.
   always_ff @(posedge clock or posedge rst) begin
      if (rst) begin
         state    <= ST_RUN;
         count    <= '0;
         addr     <= '0;
         tmo      <= '0;
         tgt_dmem <= 1'b0;
         cpu_rst  <= 1'b1;
         loading  <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         count    <= count_n;
         addr     <= addr_n;
         tmo      <= tmo_n;
         tgt_dmem <= tgt_dmem_n;
         cpu_rst  <= (state_n != ST_RUN);
         loading  <= (state_n != ST_RUN);
         err      <= (state_n == ST_ERR);
      end
   end

   // Next-state logic; prog_req overrides everything, including a same-cycle byte.
   always_comb begin
      state_n    = state;
      count_n    = count;
      addr_n     = addr;
      tmo_n      = tmo;
      tgt_dmem_n = tgt_dmem;
      asm_clr_c  = 1'b0;
      asm_byte_c = 1'b0;
      cnt_full_c = {rx_data, count[BYTE_W-1:0]};

      if (prog_req) begin
         state_n   = ST_CMD;
         tmo_n     = '0;
         asm_clr_c = 1'b1;
      end else begin
         case (state)
            ST_CMD: begin
               if (rx_valid) begin
                  tmo_n = '0;
                  case (rx_data)
                     CMD_IMEM: begin
                        tgt_dmem_n = 1'b0;
                        state_n    = ST_CNT0;
                     end
                     CMD_DMEM: begin
                        tgt_dmem_n = 1'b1;
                        state_n    = ST_CNT0;
                     end
                     CMD_END: state_n = ST_RUN;
                     default: state_n = ST_ERR;
                  endcase
               end
            end
            ST_CNT0: begin
               if (rx_valid) begin
                  count_n = {count[COUNT_W-1:BYTE_W], rx_data};
                  tmo_n   = '0;
                  state_n = ST_CNT1;
               end else if (tmo == TMO_MAX) begin
                  state_n = ST_ERR;
               end else begin
                  tmo_n = tmo + TMO_W'(1);
               end
            end
            ST_CNT1: begin
               if (rx_valid) begin
                  count_n   = cnt_full_c;
                  tmo_n     = '0;
                  addr_n    = '0;
                  asm_clr_c = 1'b1;
                  state_n   = (cnt_full_c == '0) ? ST_CMD : ST_DATA;
               end else if (tmo == TMO_MAX) begin
                  state_n = ST_ERR;
               end else begin
                  tmo_n = tmo + TMO_W'(1);
               end
            end
            ST_DATA: begin
               asm_byte_c = rx_valid;
               // Word completed last cycle: its strobe is on the ports now.
               if (word_valid) begin
                  addr_n  = addr + ADDR_W'(1);
                  count_n = count - COUNT_W'(1);
                  if (count == COUNT_W'(1)) begin
                     state_n = ST_CMD;
                  end
               end
               if (rx_valid) begin
                  tmo_n = '0;
               end else if (tmo == TMO_MAX) begin
                  state_n = ST_ERR;
               end else begin
                  tmo_n = tmo + TMO_W'(1);
               end
            end
            default: ;
         endcase
      end
   end

   assign imem_we = word_valid & ~tgt_dmem;
   assign dmem_we = word_valid & tgt_dmem;
   assign wr_addr = addr;
   assign wr_data = word_out;

endmodule

// File: tb/tb_uart_prog_loader.sv
// Self-checking bench for uart_prog_loader: a wide-address and a 2-bit-address
// instance share stimulus; write strobes are checked against scoreboards.
module tb_uart_prog_loader;

   localparam int unsigned TMO = 20;

   logic        clock = 1'b0;
   logic        rst;
   logic        prog_req;
   logic        rx_valid;
   logic [7:0]  rx_data;

   logic        a_cpu_rst, a_imem_we, a_dmem_we, a_loading, a_err;
   logic [13:0] a_wr_addr;
   logic [31:0] a_wr_data;
   logic        b_cpu_rst, b_imem_we, b_dmem_we, b_loading, b_err;
   logic [1:0]  b_wr_addr;
   logic [31:0] b_wr_data;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      bit          is_d;
      logic [13:0] addr;
      logic [31:0] data;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   ma, mb;

   typedef struct {
      bit         p;
      bit         v;
      logic [7:0] d;
      bit         exp_load;
      bit         exp_err;
   } vec_t;

   vec_t vt[12];

   always #5 clock = ~clock;

   uart_prog_loader #(.ADDR_W(14), .TIMEOUT(TMO)) dut (
      .clock(clock), .rst(rst), .prog_req(prog_req), .rx_valid(rx_valid),
      .rx_data(rx_data), .cpu_rst(a_cpu_rst), .imem_we(a_imem_we),
      .dmem_we(a_dmem_we), .wr_addr(a_wr_addr), .wr_data(a_wr_data),
      .loading(a_loading), .err(a_err)
   );

   uart_prog_loader #(.ADDR_W(2), .TIMEOUT(TMO)) dut2 (
      .clock(clock), .rst(rst), .prog_req(prog_req), .rx_valid(rx_valid),
      .rx_data(rx_data), .cpu_rst(b_cpu_rst), .imem_we(b_imem_we),
      .dmem_we(b_dmem_we), .wr_addr(b_wr_addr), .wr_data(b_wr_data),
      .loading(b_loading), .err(b_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic step(input bit p, input bit v, input logic [7:0] d);
      @(negedge clock);
      prog_req = p;
      rx_valid = v;
      rx_data  = d;
      @(posedge clock);
      #1;
      prog_req = 1'b0;
      rx_valid = 1'b0;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
   endtask

   task automatic start_section(input logic [7:0] cmd, input logic [15:0] cnt);
      step(1'b0, 1'b1, cmd);
      step(1'b0, 1'b1, cnt[7:0]);
      step(1'b0, 1'b1, cnt[15:8]);
      ma = 0;
      mb = 0;
   endtask

   task automatic send_word(input logic [31:0] w, input bit is_d);
      exp_t e;
      e.is_d = is_d;
      e.data = w;
      e.addr = 14'(ma);
      qa.push_back(e);
      e.addr = 14'(mb);
      qb.push_back(e);
      ma = ma + 1;
      mb = (mb + 1) % 4;
      for (int i = 0; i < 4; i++) step(1'b0, 1'b1, w[8*i +: 8]);
   endtask

   // Scoreboard monitors: every strobe must match the head of its queue.
   always @(negedge clock) begin
      if (!rst && (a_imem_we || a_dmem_we)) begin
         chk("a_excl", 32'(a_imem_we & a_dmem_we), 32'd0);
         if (qa.size() == 0) begin
            chk("a_unexpected_strobe", 32'({a_dmem_we, a_imem_we}), 32'd0);
         end else begin
            exp_t e;
            e = qa.pop_front();
            chk("a_we", 32'({a_dmem_we, a_imem_we}), e.is_d ? 32'd2 : 32'd1);
            chk("a_addr", 32'(a_wr_addr), 32'(e.addr));
            chk("a_data", a_wr_data, e.data);
         end
      end
   end

   always @(negedge clock) begin
      if (!rst && (b_imem_we || b_dmem_we)) begin
         chk("b_excl", 32'(b_imem_we & b_dmem_we), 32'd0);
         if (qb.size() == 0) begin
            chk("b_unexpected_strobe", 32'({b_dmem_we, b_imem_we}), 32'd0);
         end else begin
            exp_t e;
            e = qb.pop_front();
            chk("b_we", 32'({b_dmem_we, b_imem_we}), e.is_d ? 32'd2 : 32'd1);
            chk("b_addr", 32'(b_wr_addr), 32'(e.addr[1:0]));
            chk("b_data", b_wr_data, e.data);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit seen;
      rst = 1'b1; prog_req = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
      ma = 0; mb = 0;

      vt[0]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      vt[1]  = '{1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
      vt[2]  = '{1'b0, 1'b1, 8'h49, 1'b1, 1'b1};
      vt[3]  = '{1'b0, 1'b1, 8'h45, 1'b1, 1'b1};
      vt[4]  = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0};
      vt[5]  = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b0};
      vt[6]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
      vt[7]  = '{1'b0, 1'b1, 8'h00, 1'b1, 1'b0};
      vt[8]  = '{1'b0, 1'b1, 8'h45, 1'b0, 1'b0};
      vt[9]  = '{1'b0, 1'b1, 8'h49, 1'b0, 1'b0};
      vt[10] = '{1'b1, 1'b1, 8'h45, 1'b1, 1'b0};
      vt[11] = '{1'b0, 1'b1, 8'h45, 1'b0, 1'b0};

      // Reset behaviour.
      repeat (3) @(posedge clock);
      #1;
      chk("rst_cpu_rst", 32'(a_cpu_rst), 32'd1);
      chk("rst_loading", 32'(a_loading), 32'd0);
      chk("rst_err", 32'(a_err), 32'd0);
      chk("rst_we", 32'({a_imem_we, a_dmem_we}), 32'd0);
      @(negedge clock);
      rst = 1'b0;
      #1;
      chk("rst_cpu_hold", 32'(a_cpu_rst), 32'd1);
      @(posedge clock);
      #1;
      chk("rst_cpu_rel", 32'(a_cpu_rst), 32'd0);
      chk("rst_cpu_rel_b", 32'(b_cpu_rst), 32'd0);
      idle(3);
      chk("idle_cpu_rst", 32'(a_cpu_rst), 32'd0);
      chk("idle_loading", 32'(a_loading), 32'd0);
      chk("idle_err", 32'(a_err), 32'd0);

      // Command/error/arbitration vectors.
      for (int i = 0; i < 12; i++) begin
         step(vt[i].p, vt[i].v, vt[i].d);
         chk($sformatf("vec%0d_loading", i), 32'(a_loading), 32'(vt[i].exp_load));
         chk($sformatf("vec%0d_cpu_rst", i), 32'(a_cpu_rst), 32'(vt[i].exp_load));
         chk($sformatf("vec%0d_err", i), 32'(a_err), 32'(vt[i].exp_err));
      end

      // Two-word imem load then end command.
      step(1'b1, 1'b0, 8'h00);
      start_section(8'h49, 16'd2);
      send_word(32'h1234_5678, 1'b0);
      send_word(32'hDEAD_BEEF, 1'b0);
      idle(1);
      chk("load_cpu_rst_before_e", 32'(a_cpu_rst), 32'd1);
      step(1'b0, 1'b1, 8'h45);
      chk("load_cpu_rst_after_e", 32'(a_cpu_rst), 32'd0);
      chk("load_loading_after_e", 32'(a_loading), 32'd0);

      // Inter-byte timeout inside DATA.
      step(1'b1, 1'b0, 8'h00);
      start_section(8'h44, 16'd1);
      step(1'b0, 1'b1, 8'hAA);
      step(1'b0, 1'b1, 8'hBB);
      idle(TMO - 2);
      chk("tmo_not_early", 32'(a_err), 32'd0);
      seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         step(1'b0, 1'b0, 8'h00);
         seen = a_err;
      end
      chk("tmo_err", 32'(a_err), 32'd1);
      chk("tmo_cpu_rst", 32'(a_cpu_rst), 32'd1);
      step(1'b1, 1'b0, 8'h00);
      chk("tmo_err_clear", 32'(a_err), 32'd0);
      step(1'b0, 1'b1, 8'h45);
      chk("tmo_back_run", 32'(a_loading), 32'd0);

      // Five imem words (address wrap on the 2-bit instance) plus one dmem word.
      step(1'b1, 1'b0, 8'h00);
      start_section(8'h49, 16'd5);
      for (int i = 0; i < 5; i++) send_word(32'hA5A5_0000 + 32'(i * 32'h0101_0011), 1'b0);
      idle(1);
      start_section(8'h44, 16'd1);
      send_word(32'hCAFE_F00D, 1'b1);
      idle(1);
      step(1'b0, 1'b1, 8'h45);
      chk("wrap_back_run", 32'(a_loading), 32'd0);

      // prog_req mid-word and together with the fourth byte: no strobes.
      step(1'b1, 1'b0, 8'h00);
      start_section(8'h49, 16'd1);
      step(1'b0, 1'b1, 8'h11);
      step(1'b0, 1'b1, 8'h22);
      step(1'b1, 1'b0, 8'h00);
      start_section(8'h49, 16'd1);
      step(1'b0, 1'b1, 8'h11);
      step(1'b0, 1'b1, 8'h22);
      step(1'b0, 1'b1, 8'h33);
      step(1'b1, 1'b1, 8'h44);
      idle(2);
      chk("abort_in_cmd", 32'(a_loading), 32'd1);
      start_section(8'h49, 16'd1);
      send_word(32'h0BAD_F00D, 1'b0);
      idle(1);
      step(1'b0, 1'b1, 8'h45);
      chk("abort_back_run", 32'(a_loading), 32'd0);

      // Asynchronous reset in the middle of a load.
      step(1'b1, 1'b0, 8'h00);
      start_section(8'h49, 16'd1);
      step(1'b0, 1'b1, 8'h11);
      @(negedge clock);
      rst = 1'b1;
      #1;
      chk("midrst_cpu_rst", 32'(a_cpu_rst), 32'd1);
      chk("midrst_loading", 32'(a_loading), 32'd0);
      @(negedge clock);
      rst = 1'b0;
      @(posedge clock);
      #1;
      chk("midrst_release", 32'(a_cpu_rst), 32'd0);
      idle(2);

      chk("a_sb_empty", 32'(qa.size()), 32'd0);
      chk("b_sb_empty", 32'(qb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
